// File: rtl/burst_data_buffer.sv
// Bidirectional burst buffer: a read FIFO (chip -> bus) and a write FIFO (bus -> chip)
// arbitrated by a 4-state direction FSM. Define BURST_DATA_BUFFER_ERR_EN for sticky ovf/udf flags.
module bdb_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8
) (
  input  logic                       clk,
  input  logic                       n_rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [DATA_W-1:0]          din,
  output logic [DATA_W-1:0]          head,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic              push_ok, pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign pop_ok  = pop & ~empty;
  // a push into a full FIFO still lands when a pop frees the head slot this cycle
  assign push_ok = push & (~full | pop_ok);
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk)
    if (push_ok) mem[wr_ptr] <= din;

  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push_ok) - CW'(pop_ok);
    end
endmodule

module burst_data_buffer #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic                   r_enable,
  input  logic                   w_enable,
  input  logic                   bus,
  input  logic                   chip,
  input  logic [DATA_W-1:0]      c_rdata,
  input  logic [DATA_W-1:0]      b_wdata,
  output logic [DATA_W-1:0]      b_rdata,
  output logic [DATA_W-1:0]      c_wdata,
  output logic                   r_full,
  output logic                   r_empty,
  output logic                   w_full,
  output logic                   w_empty,
  output logic [$clog2(DEPTH):0] r_count,
  output logic [$clog2(DEPTH):0] w_count,
  output logic [1:0]             mode,
  output logic                   ovf,
  output logic                   udf
);
  localparam int CW = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {READ = 2'd0, TO_WRITE = 2'd1, WRITE = 2'd2, TO_READ = 2'd3} state_e;
  state_e state;

  // index 0 = read FIFO, index 1 = write FIFO
  logic [1:0]             push, pop, full, empty;
  logic [1:0][DATA_W-1:0] din, head;
  logic [1:0][CW-1:0]     count;

  assign push[0] = (state == READ) & chip;
  assign pop[0]  = ((state == READ) | (state == TO_WRITE)) & bus;
  assign push[1] = (state == WRITE) & bus;
  assign pop[1]  = ((state == WRITE) | (state == TO_READ)) & chip;
  assign din[0]  = c_rdata;
  assign din[1]  = b_wdata;

  for (genvar i = 0; i < 2; i++) begin : g_fifo
    bdb_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
      .clk(clk), .n_rst(n_rst), .push(push[i]), .pop(pop[i]), .din(din[i]),
      .head(head[i]), .count(count[i]), .full(full[i]), .empty(empty[i])
    );
  end

  assign b_rdata = head[0];
  assign c_wdata = head[1];
  assign r_count = count[0];
  assign w_count = count[1];
  assign r_full  = full[0];
  assign w_full  = full[1];
  assign r_empty = empty[0];
  assign w_empty = empty[1];
  assign mode    = state;

  // drain states finish as soon as the outgoing FIFO is empty, regardless of enables
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) state <= READ;
    else
      unique case (state)
        READ:     if (!r_enable && w_enable) state <= TO_WRITE;
        TO_WRITE: if (empty[0]) state <= WRITE;
                  else if (r_enable && !w_enable) state <= READ;
        WRITE:    if (r_enable && !w_enable) state <= TO_READ;
        TO_READ:  if (empty[1]) state <= READ;
                  else if (w_enable && !r_enable) state <= WRITE;
        default:  state <= READ;
      endcase

`ifdef BURST_DATA_BUFFER_ERR_EN
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      if (|(push & full & ~pop)) ovf <= 1'b1;
      if (|(pop & empty))        udf <= 1'b1;
    end
`else
  assign ovf = 1'b0;
  assign udf = 1'b0;
`endif
endmodule

// File: tb/tb_burst_data_buffer.sv
// Directed bench for burst_data_buffer (DATA_W=32, DEPTH=4) with hand-computed expectations.
module tb_burst_data_buffer;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;
`ifdef BURST_DATA_BUFFER_ERR_EN
  localparam logic ERR = 1'b1;
`else
  localparam logic ERR = 1'b0;
`endif

  logic              clk, n_rst, r_enable, w_enable, bus, chip;
  logic [DATA_W-1:0] c_rdata, b_wdata, b_rdata, c_wdata;
  logic              r_full, r_empty, w_full, w_empty, ovf, udf;
  logic [2:0]        r_count, w_count;
  logic [1:0]        mode;
  int                n_checks, n_errs;

  burst_data_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .n_rst(n_rst), .r_enable(r_enable), .w_enable(w_enable),
    .bus(bus), .chip(chip), .c_rdata(c_rdata), .b_wdata(b_wdata),
    .b_rdata(b_rdata), .c_wdata(c_wdata), .r_full(r_full), .r_empty(r_empty),
    .w_full(w_full), .w_empty(w_empty), .r_count(r_count), .w_count(w_count),
    .mode(mode), .ovf(ovf), .udf(udf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // one clock edge with whatever strobes are set, then strobes drop
  task automatic tick();
    @(posedge clk);
    #1;
    bus  = 1'b0;
    chip = 1'b0;
  endtask

  initial begin
    n_checks = 0; n_errs = 0;
    n_rst = 1'b0; r_enable = 1'b1; w_enable = 1'b0; bus = 1'b0; chip = 1'b0;
    c_rdata = '0; b_wdata = '0;
    #12;
    chk("rst_mode", mode, 0);
    chk("rst_rcnt", r_count, 0);
    chk("rst_wcnt", w_count, 0);
    chk("rst_rempty", r_empty, 1);
    chk("rst_wempty", w_empty, 1);
    chk("rst_rfull", r_full, 0);
    chk("rst_brdata", b_rdata, 0);
    chk("rst_cwdata", c_wdata, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_udf", udf, 0);
    n_rst = 1'b1;
    #1;

    // fill read FIFO, then overflow
    for (int i = 0; i < 4; i++) begin
      chip = 1'b1; c_rdata = 32'hA0 + i; tick();
    end
    chk("fill_rcnt", r_count, 4);
    chk("fill_rfull", r_full, 1);
    chk("fill_head", b_rdata, 32'hA0);
    chk("fill_ovf0", ovf, 0);
    chip = 1'b1; c_rdata = 32'hA4; tick();
    chk("drop_rcnt", r_count, 4);
    chk("drop_head", b_rdata, 32'hA0);
    chk("drop_ovf", ovf, ERR);

    // drain in order, then underflow
    for (int i = 0; i < 4; i++) begin
      chk("drain_head", b_rdata, 32'hA0 + i);
      bus = 1'b1; tick();
    end
    chk("drain_brdata0", b_rdata, 0);
    chk("drain_rempty", r_empty, 1);
    chk("drain_udf0", udf, 0);
    bus = 1'b1; tick();
    chk("udf_set", udf, ERR);
    chk("udf_rcnt", r_count, 0);

    // READ -> TO_WRITE with 2 words, drain, then WRITE
    chip = 1'b1; c_rdata = 32'h10; tick();
    chip = 1'b1; c_rdata = 32'h11; tick();
    r_enable = 1'b0; w_enable = 1'b1; tick();
    chk("tw_mode", mode, 1);
    chip = 1'b1; bus = 1'b1; c_rdata = 32'h12; tick();
    chk("tw_pushblk", r_count, 1);
    chk("tw_head", b_rdata, 32'h11);
    bus = 1'b1; tick();
    chk("tw_empty", r_empty, 1);
    chk("tw_mode_hold", mode, 1);
    tick();
    chk("w_mode", mode, 2);
    bus = 1'b1; b_wdata = 32'hB0; tick();
    chk("w_head", c_wdata, 32'hB0);
    chk("w_cnt1", w_count, 1);
    chip = 1'b1; tick();
    chk("w_pop", w_count, 0);
    chk("w_rcnt_untouched", r_count, 0);

    // six pushes, one pop after the third: D0 popped, D5 dropped
    for (int i = 0; i < 6; i++) begin
      bus = 1'b1; b_wdata = 32'hD0 + i; tick();
      if (i == 2) begin chip = 1'b1; tick(); end
    end
    chk("wrap_wcnt", w_count, 4);
    chk("wrap_wfull", w_full, 1);
    for (int i = 1; i < 5; i++) begin
      chk("wrap_order", c_wdata, 32'hD0 + i);
      chip = 1'b1; tick();
    end
    chk("wrap_wempty", w_empty, 1);
    chk("wrap_cwdata0", c_wdata, 0);

    // WRITE -> TO_READ -> READ (write FIFO already empty)
    r_enable = 1'b1; w_enable = 1'b0; tick();
    chk("tr_mode", mode, 3);
    tick();
    chk("r_mode", mode, 0);

    // three words then TO_WRITE, reset mid-transfer
    for (int i = 0; i < 3; i++) begin
      chip = 1'b1; c_rdata = 32'hE0 + i; tick();
    end
    r_enable = 1'b0; w_enable = 1'b1; tick();
    chk("pre_rst_mode", mode, 1);
    chk("pre_rst_rcnt", r_count, 3);
    n_rst = 1'b0;
    #1;
    chk("mid_rst_mode", mode, 0);
    chk("mid_rst_rcnt", r_count, 0);
    chk("mid_rst_brdata", b_rdata, 0);
    chk("mid_rst_rempty", r_empty, 1);
    chk("mid_rst_ovf", ovf, 0);
    #10;
    n_rst = 1'b1;
    #1;

    // go to WRITE, fill, simultaneous push+pop on full FIFO
    tick();
    chk("re_tw_mode", mode, 1);
    tick();
    chk("re_w_mode", mode, 2);
    for (int i = 1; i < 5; i++) begin
      bus = 1'b1; b_wdata = 32'hC0 + i; tick();
    end
    chk("pp_wfull", w_full, 1);
    bus = 1'b1; chip = 1'b1; b_wdata = 32'hC0; tick();
    chk("pp_wcnt", w_count, 4);
    chk("pp_ovf", ovf, 0);
    chk("pp_head", c_wdata, 32'hC2);
    for (int i = 0; i < 3; i++) begin
      chip = 1'b1; tick();
    end
    chk("pp_tail", c_wdata, 32'hC0);
    chk("pp_wcnt1", w_count, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end
endmodule
